// File: rtl/lb_pkg.sv
// Shared definitions for the 3x3 line-buffer sequencer: layer_code field layout,
// controller states and the read-pipeline depth.
package lb_pkg;

  localparam int LC_FIELD_W = 10;
  localparam int LC_W1_LSB  = 0;
  localparam int LC_H1_LSB  = 10;

  // Cycles from an accept until the line buffer presents the resulting window.
  localparam int LB_RD_LAT  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } lb_state_t;

endpackage

// File: rtl/lb_pos_counter.sv
// Column/row position counter for the line buffer. Column wraps by explicit
// compare against w1; row saturates at h1 so neither ever passes its limit.
module lb_pos_counter #(
  parameter int COL_BITS = 10,
  parameter int ROW_BITS = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [COL_BITS-1:0] w1,
  input  logic [ROW_BITS-1:0] h1,
  output logic [COL_BITS-1:0] col,
  output logic [ROW_BITS-1:0] row,
  output logic                last_col,
  output logic                last_row
);

  assign last_col = (col == w1);
  assign last_row = (row == h1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (enable) begin
      if (last_col) begin
        col <= '0;
        if (!last_row) row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Sequencer for one 3x3 line buffer: accepts pixel columns, drives the RAM
// address/write/select and flags when a full 3-row window is available.
module line_buffer_ctrl
  import lb_pkg::*;
#(
  parameter int LC_bits   = 20,
  parameter int ADDR_bits = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LC_bits-1:0]   layer_code,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ADDR_bits-1:0] addr,
  output logic                 wea,
  output logic                 sel,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  lb_state_t state_reg, state_next;
  logic [1:0] flush_cnt_reg, flush_cnt_next;

  logic [ADDR_bits-1:0]  w1_reg;
  logic [LC_FIELD_W-1:0] h1_reg;

  logic [ADDR_bits-1:0]  col;
  logic [LC_FIELD_W-1:0] row;
  logic last_col, last_row;

  logic accept, take_start, flush_end;
  logic [ADDR_bits-1:0] addr_reg;
  logic wea_reg, sel_reg, done_reg;
  logic [LB_RD_LAT-1:0] ov_pipe_reg;

  assign in_ready = (state_reg == RUN);
  assign busy     = (state_reg != IDLE);
  assign accept   = in_valid & in_ready;

  lb_pos_counter #(
    .COL_BITS(ADDR_bits),
    .ROW_BITS(LC_FIELD_W)
  ) u_pos (
    .clk      (clk),
    .reset    (reset),
    .clear    (take_start),
    .enable   (accept),
    .w1       (w1_reg),
    .h1       (h1_reg),
    .col      (col),
    .row      (row),
    .last_col (last_col),
    .last_row (last_row)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  // A start landing on the done cycle belongs to the finished layer's consumer
  // handshake, so it is deliberately dropped.
  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    take_start     = 1'b0;
    flush_end      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !done_reg) begin
          take_start = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        flush_cnt_next = '0;
        if (accept && last_col && last_row) state_next = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt_reg == 2'(LB_RD_LAT - 1)) begin
          flush_end  = 1'b1;
          state_next = IDLE;
        end else begin
          flush_cnt_next = flush_cnt_reg + 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w1_reg   <= '0;
      h1_reg   <= '0;
      addr_reg <= '0;
      wea_reg  <= 1'b0;
      sel_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      if (take_start) begin
        w1_reg <= ADDR_bits'(layer_code[LC_W1_LSB +: LC_FIELD_W]);
        h1_reg <= layer_code[LC_H1_LSB +: LC_FIELD_W];
      end
      wea_reg <= accept;
      if (accept) addr_reg <= col;
      // RAM holds a valid previous row from the first accept of row 1 onward.
      if (flush_end)             sel_reg <= 1'b0;
      else if (accept && row != '0) sel_reg <= 1'b1;
      done_reg <= flush_end;
    end
  end

  // Window-valid is the accept pulse of rows >= 2, delayed by the read pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ov_pipe_reg <= '0;
    end else begin
      for (int i = LB_RD_LAT - 1; i > 0; i--) ov_pipe_reg[i] <= ov_pipe_reg[i-1];
      ov_pipe_reg[0] <= accept && (row >= LC_FIELD_W'(2));
    end
  end

  assign addr      = addr_reg;
  assign wea       = wea_reg;
  assign sel       = sel_reg;
  assign done      = done_reg;
  assign out_valid = ov_pipe_reg[LB_RD_LAT-1];

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Randomized self-checking bench for line_buffer_ctrl against an accept-index
// reference model (column = k mod width, row = k div width).
module tb_line_buffer_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [19:0] layer_code;
  logic        in_ready, wea, sel, out_valid, busy, done;
  logic [9:0]  addr;

  int checks = 0;
  int errors = 0;

  line_buffer_ctrl #(.LC_bits(20), .ADDR_bits(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .layer_code (layer_code),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .addr       (addr),
    .wea        (wea),
    .sel        (sel),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  0);
    chk({tag, "_addr"},      32'(addr),      0);
    chk({tag, "_wea"},       32'(wea),       0);
    chk({tag, "_sel"},       32'(sel),       0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_done"},      32'(done),      0);
  endtask

  // mode: 0 = in_valid held high, 1 = toggling 1,0, 2 = random.
  // abort_at >= 0 asserts reset once that many columns were accepted.
  task automatic run_layer(input int w1, input int h1, input int mode,
                           input bit mid_start, input bit start_on_done, input int abort_at);
    int total, acc_cnt, prev1, prev2, cur, since, ov_cnt, exp_ov, width;
    bit iv;
    width   = w1 + 1;
    total   = width * (h1 + 1);
    exp_ov  = (h1 >= 2) ? (h1 - 1) * width : 0;
    acc_cnt = 0; prev1 = -1; prev2 = -1; since = -1; ov_cnt = 0;

    layer_code = {h1[9:0], w1[9:0]};
    start      = 1'b1;
    in_valid   = 1'($urandom % 2);
    @(posedge clk); #1;
    start = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      chk("in_ready",  32'(in_ready),  32'(acc_cnt < total));
      chk("busy",      32'(busy),      32'(since < 3));
      chk("done",      32'(done),      32'(since == 3));
      chk("wea",       32'(wea),       32'(prev1 >= 0));
      if (prev1 >= 0) begin
        chk("addr", 32'(addr), 32'(prev1 % width));
        chk("sel",  32'(sel),  32'((prev1 / width) >= 1));
      end
      chk("out_valid", 32'(out_valid), 32'(prev2 >= 0 && (prev2 / width) >= 2));
      if (out_valid === 1'b1) ov_cnt++;
      if (since == 3) break;

      if (abort_at >= 0 && acc_cnt == abort_at) begin
        #2 reset = 1'b1;
        #1 chk_all_zero("mid_reset");
        @(posedge clk); #1;
        chk_all_zero("held_reset");
        reset = 1'b0;
        in_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
          @(posedge clk); #1;
          chk("post_reset_done", 32'(done), 0);
          chk("post_reset_busy", 32'(busy), 0);
        end
        $display("layer W1=%0d H1=%0d aborted by reset after %0d accepts", w1, h1, acc_cnt);
        return;
      end

      case (mode)
        0:       iv = 1'b1;
        1:       iv = (cyc % 2 == 0);
        default: iv = ($urandom % 4 != 0);
      endcase
      in_valid = iv;
      if (mid_start && cyc == 5) begin
        start      = 1'b1;
        layer_code = 20'h00802;
      end

      cur = (iv && acc_cnt < total) ? acc_cnt : -1;
      if (cur >= 0) begin
        acc_cnt++;
        if (acc_cnt == total) since = 0;
      end

      @(posedge clk); #1;
      start = 1'b0;
      prev2 = prev1;
      prev1 = cur;
      if (since >= 0) since++;
    end

    chk("done_reached", 32'(since), 3);
    chk("ov_count", 32'(ov_cnt), 32'(exp_ov));

    // Done cycle: a start here must be ignored.
    start      = start_on_done;
    layer_code = 20'h00C03;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("after_done_ready", 32'(in_ready), 0);
    chk("after_done_busy",  32'(busy),     0);
    chk("after_done_done",  32'(done),     0);
    $display("layer W1=%0d H1=%0d mode=%0d accepts=%0d out_valid=%0d", w1, h1, mode, acc_cnt, ov_cnt);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; layer_code = '0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("idle");

    run_layer(3, 3, 0, 1'b0, 1'b0, -1);
    run_layer(3, 3, 1, 1'b0, 1'b0, -1);
    run_layer(0, 4, 2, 1'b0, 1'b0, -1);
    run_layer(2, 1, 0, 1'b0, 1'b0, -1);
    run_layer(7, 7, 0, 1'b0, 1'b0, 20);
    run_layer(3, 3, 0, 1'b0, 1'b0, -1);
    run_layer(5, 3, 2, 1'b1, 1'b1, -1);
    run_layer(4, 2, 0, 1'b0, 1'b0, -1);
    for (int n = 0; n < 5; n++)
      run_layer(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)), 2,
                1'($urandom % 2), 1'($urandom % 2), -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
